// File: rtl/parser_lane_arbiter.sv
// Packet-atomic round-robin merge of N parser lanes into one {clear, tlast, data} stream.
// A granted lane owns the output until its packet-ending beat (tlast or clear) is accepted.
module parser_lane_arbiter #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = $clog2(N_LANES),
  parameter int DATA_W  = 34
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_LANES*DATA_W-1:0]   s_tdata,
  input  logic [N_LANES-1:0]          s_tvalid,
  output logic [N_LANES-1:0]          s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [LANE_W-1:0]           m_lane,
  output logic [31:0]                 pkt_count,
  output logic                        fsm_state
);

  // Handshake: a beat moves on either side only in a cycle where valid and ready are both high;
  // m_tvalid follows the granted lane's s_tvalid and that lane's s_tready follows m_tready.

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_n;
  logic [LANE_W-1:0]   grant, grant_n;
  logic [LANE_W-1:0]   last_grant, last_grant_n;
  logic [31:0]         pkt_count_n;

  logic [DATA_W-1:0]   sel_data;
  logic                sel_valid;
  logic                found;
  logic [LANE_W-1:0]   pick;
  logic [LANE_W-1:0]   cand;
  logic                pkt_end;

  assign fsm_state = (state == LOCKED);

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (grant == LANE_W'(i)) begin
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
        sel_valid = s_tvalid[i];
      end
    end
  end

  // Round-robin search starting just after the lane that last completed a packet.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= N_LANES; i++) begin
      cand = LANE_W'((int'(last_grant) + i) % N_LANES);
      if (!found && s_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pkt_end = m_tvalid & m_tready & (sel_data[DATA_W-1] | sel_data[DATA_W-2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LANE_W'(N_LANES - 1);
      pkt_count  <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      pkt_count  <= pkt_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    pkt_count_n  = pkt_count;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = LOCKED;
          grant_n = pick;
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          state_n      = IDLE;
          last_grant_n = grant;
          pkt_count_n  = pkt_count + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high, even before the synchronous reset lands.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_lane   = '0;
    s_tready = '0;
    if (!rst && state == LOCKED) begin
      m_tdata  = sel_data;
      m_tvalid = sel_valid;
      m_lane   = grant;
      for (int i = 0; i < N_LANES; i++) begin
        s_tready[i] = (grant == LANE_W'(i)) & m_tready;
      end
    end
  end

endmodule

// File: tb/tb_parser_lane_arbiter.sv
// Directed bench for parser_lane_arbiter: vector table for reset/clear/idle-bubble cases,
// queue-driven sequences for streaming, round robin, backpressure and mid-packet reset.
module tb_parser_lane_arbiter;

  localparam int N = 4;
  localparam int W = 34;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   s_tdata;
  logic [N-1:0]     s_tvalid;
  logic [N-1:0]     s_tready;
  logic [W-1:0]     m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [1:0]       m_lane;
  logic [31:0]      pkt_count;
  logic             fsm_state;

  int n_vec = 0;
  int n_err = 0;

  logic [35:0] exp_q[$];
  logic [33:0] lane_q[4][$];
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [1:0]  sel;
    logic [33:0] beat;
    logic        rdy;
    logic        e_valid;
    logic [33:0] e_data;
    logic [1:0]  e_lane;
    logic [3:0]  e_ready;
    logic [31:0] e_pkt;
  } vec_t;

  vec_t tbl[12];

  parser_lane_arbiter #(.N_LANES(N), .LANE_W(2), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_lane    (m_lane),
    .pkt_count (pkt_count),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_pkt(input int lane, input int n, input logic [31:0] base);
    logic [33:0] b;
    for (int k = 0; k < n; k++) begin
      b = {1'b0, (k == n - 1), base + 32'(k)};
      lane_q[lane].push_back(b);
      exp_q.push_back({2'(lane), b});
    end
  endtask

  task automatic drive_lanes(input bit rdy);
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*W +: W]   = lane_q[i][0];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*W +: W]   = '0;
      end
    end
    m_tready = rdy;
  endtask

  // One cycle per iteration: drive at posedge+1, observe and consume at negedge.
  task automatic run(input string tag, input int budget, input int stop_after, input bit use_pat,
                     output int first_x, output int last_x);
    int          nx;
    bit          stall;
    logic [33:0] pd;
    logic [1:0]  pl;
    logic [35:0] e;
    nx = 0;
    stall = 1'b0;
    pd = '0;
    pl = '0;
    first_x = -1;
    last_x = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      drive_lanes(use_pat ? pat[cyc % 4] : 1'b1);
      @(negedge clk);
      if (stall) chk({tag, "_stall_hold"}, {m_tvalid, m_lane, m_tdata}, {1'b1, pl, pd});
      if (m_tvalid) chk({tag, "_s_tready"}, s_tready, 4'(m_tready) << m_lane);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s_extra_beat: got lane %0d data %h expected no beat", tag, m_lane, m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_beat"}, {m_lane, m_tdata}, e);
        end
        nx++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      stall = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_lane;
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) void'(lane_q[i].pop_front());
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 || nx == stop_after) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL %s_timeout: got %0d beats pending expected 0 after %0d cycles", tag, exp_q.size(), budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int f, l;
    //          rst  vld     sel  beat             rdy  ev   edata            el   erdy    epkt
    tbl[0]  = '{1'b1, 4'b1111, 2'd0, 34'h0_00000001, 1'b1, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd0};
    tbl[1]  = '{1'b1, 4'b1111, 2'd1, 34'h0_00000002, 1'b1, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd0};
    tbl[2]  = '{1'b1, 4'b1111, 2'd2, 34'h0_00000003, 1'b1, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd0};
    tbl[3]  = '{1'b0, 4'b1000, 2'd3, 34'h3_DEADBEEF, 1'b1, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd0};
    tbl[4]  = '{1'b0, 4'b1000, 2'd3, 34'h3_DEADBEEF, 1'b1, 1'b1, 34'h3_DEADBEEF,  2'd3, 4'b1000, 32'd0};
    tbl[5]  = '{1'b0, 4'b1111, 2'd0, 34'h1_00000011, 1'b1, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd1};
    tbl[6]  = '{1'b0, 4'b1111, 2'd0, 34'h1_00000011, 1'b1, 1'b1, 34'h1_00000011,  2'd0, 4'b0001, 32'd1};
    tbl[7]  = '{1'b0, 4'b0000, 2'd0, 34'h0_00000000, 1'b1, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd2};
    tbl[8]  = '{1'b0, 4'b0010, 2'd1, 34'h0_00000055, 1'b0, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd2};
    tbl[9]  = '{1'b0, 4'b0010, 2'd1, 34'h0_00000055, 1'b0, 1'b1, 34'h0_00000055,  2'd1, 4'b0000, 32'd2};
    tbl[10] = '{1'b0, 4'b0010, 2'd1, 34'h1_00000056, 1'b1, 1'b1, 34'h1_00000056,  2'd1, 4'b0010, 32'd2};
    tbl[11] = '{1'b0, 4'b0000, 2'd0, 34'h0_00000000, 1'b1, 1'b0, 34'h0,           2'd0, 4'b0000, 32'd3};

    rst      = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;

    // Reset with all lanes valid, clear beat on lane 3, re-search from lane 0, stall then close.
    for (int k = 0; k < 12; k++) begin
      rst      = tbl[k].rst;
      m_tready = tbl[k].rdy;
      s_tvalid = tbl[k].vld;
      for (int i = 0; i < N; i++) begin
        s_tdata[i*W +: W] = (i == int'(tbl[k].sel)) ? tbl[k].beat : (34'h0_0BAD0000 | 34'(i));
      end
      @(negedge clk);
      chk($sformatf("v%0d_m_tvalid", k),  m_tvalid,  tbl[k].e_valid);
      chk($sformatf("v%0d_m_tdata", k),   m_tdata,   tbl[k].e_data);
      chk($sformatf("v%0d_m_lane", k),    m_lane,    tbl[k].e_lane);
      chk($sformatf("v%0d_s_tready", k),  s_tready,  tbl[k].e_ready);
      chk($sformatf("v%0d_pkt_count", k), pkt_count, tbl[k].e_pkt);
      @(posedge clk);
      #1;
    end

    // Single lane 2, 16 beats.
    do_reset(2);
    push_pkt(2, 16, 32'd0);
    run("t2", 60, -1, 1'b0, f, l);
    chk("t2_first_latency", 64'(f), 64'd1);
    chk("t2_pkt_count", pkt_count, 32'd1);

    // All lanes, two 2-beat packets each: order 0,1,2,3,0,1,2,3 with one bubble per packet.
    do_reset(2);
    for (int p = 0; p < 2; p++) begin
      for (int ln = 0; ln < N; ln++) push_pkt(ln, 2, 32'(ln << 8) | 32'(p << 4));
    end
    run("t3", 100, -1, 1'b0, f, l);
    chk("t3_last_xfer_cycle", 64'(l), 64'd23);
    chk("t3_pkt_count", pkt_count, 32'd8);

    // Backpressure on lane 1.
    do_reset(2);
    push_pkt(1, 5, 32'h100);
    run("t4", 100, -1, 1'b1, f, l);
    chk("t4_pkt_count", pkt_count, 32'd1);
    chk("t4_lane1_drained", 64'(lane_q[1].size()), 64'd0);

    // Reset after 3 of 8 beats on lane 0; remaining 5 beats come out as a new packet.
    push_pkt(0, 8, 32'h60);
    run("t6a", 50, 3, 1'b0, f, l);
    chk("t6_pkt_before", pkt_count, 32'd1);
    rst = 1'b1;
    drive_lanes(1'b1);
    @(negedge clk);
    chk("t6_rst_m_tvalid", m_tvalid, 1'b0);
    chk("t6_rst_s_tready", s_tready, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_lanes(1'b1);
    @(negedge clk);
    chk("t6_post_m_tvalid", m_tvalid, 1'b0);
    chk("t6_post_pkt_count", pkt_count, 32'd0);
    chk("t6_post_state", fsm_state, 1'b0);
    chk("t6_post_s_tready", s_tready, 4'b0000);
    @(posedge clk);
    #1;
    run("t6b", 50, -1, 1'b0, f, l);
    chk("t6_regrant_latency", 64'(f), 64'd0);
    chk("t6_pkt_after", pkt_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
